hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage rv32i core. Generates the rs1/rs2 forwarding-mux
//  selects for the decode stage, stage-register load enables, load-use bubbles and branch squashes.
//  Stalls the whole pipe while I-/D-memory are not ready, and keeps a memory-timeout watchdog
//  plus stall/flush performance counters. Sits beside the datapath; drives every stage register.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  consecutive not-ready cycles before mem_timeout asserts (>=2)
//  CNT_W           32    width of the performance counters
// PORTS
//  clk              in   1      clock; single clock domain
//  reset            in   1      synchronous, active-high reset
//  resp_a           in   1      I-memory response/ready
//  resp_b           in   1      D-memory response/ready (high when no D access)
//  dec_valid        in   1      DEC stage holds a real instruction
//  dec_rs1_num      in   5      DEC source register 1
//  dec_rs2_num      in   5      DEC source register 2
//  ex_valid         in   1      EX stage holds a real instruction
//  ex_rd            in   5      EX destination
//  ex_load_regfile  in   1      EX instruction writes rd
//  ex_is_load       in   1      EX instruction is a load
//  br_taken         in   1      EX resolved taken branch/jump (qualified by ex_valid)
//  mem_valid        in   1      MEM stage valid
//  mem_rd           in   5      MEM destination
//  mem_load_regfile in   1      MEM instruction writes rd
//  fwd_rs1_sel      out  2      00 regfile, 01 mem_forward, 10 exec_forward
//  fwd_rs2_sel      out  2      same encoding
//  load_pc          out  1      PC register load enable
//  load_if_dec      out  1      IF/DEC register load enable
//  load_dec_ex      out  1      DEC/EX register load enable
//  load_ex_wb       out  1      EX/MEM and MEM/WB register load enable
//  squash_if_dec    out  1      write invalid (valid=0) into IF/DEC on this load
//  squash_dec_ex    out  1      write bubble into DEC/EX on this load
//  mem_timeout      out  1      sticky watchdog flag
//  stall_count      out  CNT_W  cycles with mem_ready=0 or load-use bubble
//  flush_count      out  CNT_W  taken-branch flushes performed
// BEHAVIOUR
//  - mem_ready = resp_a & resp_b. Priority: reset > memory stall > branch flush > load-use > run.
//  - Forwarding (combinational, per source s): s==0 -> 00. ex_valid&ex_load_regfile&ex_rd==s&!ex_is_load
//    -> 10; else mem_valid&mem_load_regfile&mem_rd==s -> 01; else 00. EX wins over MEM.
//  - Load-use: dec_valid & ex_valid & ex_is_load & ex_rd!=0 & ex_rd in {rs1,rs2}. With mem_ready:
//    load_pc=load_if_dec=0, load_dec_ex=1 with squash_dec_ex=1, load_ex_wb=1. One bubble only;
//    next cycle the load is in MEM and forwards via 01.
//  - Branch flush: ex_valid&br_taken&mem_ready -> all loads 1, squash_if_dec=squash_dec_ex=1,
//    flush_count++. Overrides load-use in the same cycle (dependent instr is squashed).
//  - Memory stall: mem_ready=0 -> all load_* 0, squashes 0; br_taken is held by EX regs and
//    is acted on in the first mem_ready cycle (never lost, never doubled).
//  - Run: all loads 1, squashes 0. Outputs are combinational; 0-cycle latency.
//  - FSM (registered, 2b): RUN->MEM_WAIT when mem_ready=0; MEM_WAIT->RUN when mem_ready=1;
//    MEM_WAIT->TIMEOUT when wait counter reaches TIMEOUT_CYCLES-1 while still not ready.
//    TIMEOUT is sticky until reset; mem_timeout=(state==TIMEOUT); pipe control unchanged in TIMEOUT.
//  - Wait counter clears on every mem_ready=1 cycle; saturates, never wraps.
//  - stall_count/flush_count wrap modulo 2^CNT_W. A flush cycle is not a stall cycle.
//  - Reset: state RUN, counters 0, mem_timeout 0, all load_* 0, squashes 0, fwd selects 00.
//    Reset mid-stall discards wait count and any pending flush.
// STRUCTURE
//  - Package rv32i_types: hazard_state_t enum {RUN, MEM_WAIT, TIMEOUT}, fwd_sel_t encoding constants.
//  - One sub-module: fwd_unit (combinational compare for one source), instantiated twice.
//  - Counters and FSM in the top module.
// TESTING
//  1 ex: addi x5 (ex_rd=5,ld=1), dec rs1=5 -> fwd_rs1_sel=10; same with mem_rd=5 only -> 01; rs1=0 -> 00.
//  2 ex load x7, dec rs2=7 -> 1 cycle: load_pc=0,squash_dec_ex=1; next cycle fwd_rs2_sel=01, all loads 1.
//  3 br_taken with load-use same cycle -> both squashes 1, load_pc=1, flush_count 0->1, no bubble.
//  4 resp_b=0 for 3 cycles with br_taken held -> loads 0 for 3 cycles, then one flush; stall_count=3.
//  5 resp_a=0 for TIMEOUT_CYCLES cycles (param 8) -> mem_timeout=1 after 8th, stays after resp_a=1.
//  6 reset asserted during MEM_WAIT -> next cycle state RUN, counters 0, mem_timeout 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the rv32i pipeline hazard controller.
package rv32i_types;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        TIMEOUT  = 2'b10
    } hazard_state_t;

    // Forwarding-mux select encoding seen by the decode-stage operand muxes.
    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_EX  = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one decode-stage source operand; EX result wins over MEM.
module fwd_unit
    import rv32i_types::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             ex_valid,
    input  logic             ex_load_regfile,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_valid,
    input  logic             mem_load_regfile,
    input  logic [REG_W-1:0] mem_rd,
    output fwd_sel_t         sel_c
);

    // x0 never forwards; a load in EX has no data yet so it is skipped here.
    always_comb begin
        sel_c = FWD_RF;
        if (src != '0) begin
            if (ex_valid && ex_load_regfile && !ex_is_load && (ex_rd == src)) begin
                sel_c = FWD_EX;
            end else if (mem_valid && mem_load_regfile && (mem_rd == src)) begin
                sel_c = FWD_MEM;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, stage load enables, bubbles, squashes,
// memory-timeout watchdog and stall/flush counters.
module hazard_ctrl
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             resp_a,
    input  logic             resp_b,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs1_num,
    input  logic [REG_W-1:0] dec_rs2_num,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_load_regfile,
    input  logic             ex_is_load,
    input  logic             br_taken,
    input  logic             mem_valid,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_load_regfile,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic             load_pc,
    output logic             load_if_dec,
    output logic             load_dec_ex,
    output logic             load_ex_wb,
    output logic             squash_if_dec,
    output logic             squash_dec_ex,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;

    hazard_state_t     state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    fwd_sel_t rs1_sel_c, rs2_sel_c;
    logic     mem_ready_c, load_use_c, flush_c;

    fwd_unit u_fwd_rs1 (
        .src              (dec_rs1_num),
        .ex_valid         (ex_valid),
        .ex_load_regfile  (ex_load_regfile),
        .ex_is_load       (ex_is_load),
        .ex_rd            (ex_rd),
        .mem_valid        (mem_valid),
        .mem_load_regfile (mem_load_regfile),
        .mem_rd           (mem_rd),
        .sel_c            (rs1_sel_c)
    );

    fwd_unit u_fwd_rs2 (
        .src              (dec_rs2_num),
        .ex_valid         (ex_valid),
        .ex_load_regfile  (ex_load_regfile),
        .ex_is_load       (ex_is_load),
        .ex_rd            (ex_rd),
        .mem_valid        (mem_valid),
        .mem_load_regfile (mem_load_regfile),
        .mem_rd           (mem_rd),
        .sel_c            (rs2_sel_c)
    );

    // Hazard conditions; a flush only happens once both memories are ready.
    always_comb begin
        mem_ready_c = resp_a & resp_b;
        load_use_c  = dec_valid & ex_valid & ex_is_load & (ex_rd != '0) &
                      ((ex_rd == dec_rs1_num) | (ex_rd == dec_rs2_num));
        flush_c     = ex_valid & br_taken & mem_ready_c;
    end

    // Pipe control, FSM next state and counter updates.
    always_comb begin
        fwd_rs1_sel   = FWD_RF;
        fwd_rs2_sel   = FWD_RF;
        load_pc       = 1'b0;
        load_if_dec   = 1'b0;
        load_dec_ex   = 1'b0;
        load_ex_wb    = 1'b0;
        squash_if_dec = 1'b0;
        squash_dec_ex = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;

        if (!reset) begin
            fwd_rs1_sel = rs1_sel_c;
            fwd_rs2_sel = rs2_sel_c;

            if (!mem_ready_c) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end else if (flush_c) begin
                load_pc       = 1'b1;
                load_if_dec   = 1'b1;
                load_dec_ex   = 1'b1;
                load_ex_wb    = 1'b1;
                squash_if_dec = 1'b1;
                squash_dec_ex = 1'b1;
                flush_count_d = flush_count_q + CNT_W'(1);
            end else if (load_use_c) begin
                load_dec_ex   = 1'b1;
                load_ex_wb    = 1'b1;
                squash_dec_ex = 1'b1;
                stall_count_d = stall_count_q + CNT_W'(1);
            end else begin
                load_pc     = 1'b1;
                load_if_dec = 1'b1;
                load_dec_ex = 1'b1;
                load_ex_wb  = 1'b1;
            end

            if (mem_ready_c) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != '1) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end

            unique case (state_q)
                RUN: begin
                    if (!mem_ready_c) state_d = MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (mem_ready_c) begin
                        state_d = RUN;
                    end else if (wait_cnt_q >= WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = TIMEOUT;
                    end
                end
                TIMEOUT: state_d = TIMEOUT;
                default: state_d = RUN;
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Registered status outputs.
    always_comb begin
        mem_timeout = (state_q == TIMEOUT);
        stall_count = stall_count_q;
        flush_count = flush_count_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (TIMEOUT_CYCLES=8).
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        resp_a, resp_b;
    logic        dec_valid;
    logic [4:0]  dec_rs1_num, dec_rs2_num;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_load_regfile, ex_is_load, br_taken;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_load_regfile;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic        load_pc, load_if_dec, load_dec_ex, load_ex_wb;
    logic        squash_if_dec, squash_dec_ex, mem_timeout;
    logic [31:0] stall_count, flush_count;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .resp_a           (resp_a),
        .resp_b           (resp_b),
        .dec_valid        (dec_valid),
        .dec_rs1_num      (dec_rs1_num),
        .dec_rs2_num      (dec_rs2_num),
        .ex_valid         (ex_valid),
        .ex_rd            (ex_rd),
        .ex_load_regfile  (ex_load_regfile),
        .ex_is_load       (ex_is_load),
        .br_taken         (br_taken),
        .mem_valid        (mem_valid),
        .mem_rd           (mem_rd),
        .mem_load_regfile (mem_load_regfile),
        .fwd_rs1_sel      (fwd_rs1_sel),
        .fwd_rs2_sel      (fwd_rs2_sel),
        .load_pc          (load_pc),
        .load_if_dec      (load_if_dec),
        .load_dec_ex      (load_dec_ex),
        .load_ex_wb       (load_ex_wb),
        .squash_if_dec    (squash_if_dec),
        .squash_dec_ex    (squash_dec_ex),
        .mem_timeout      (mem_timeout),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {load_pc, load_if_dec, load_dec_ex, load_ex_wb, squash_if_dec, squash_dec_ex}
    task automatic check_ctl(input string tag, input logic [5:0] exp);
        check(tag, 32'({load_pc, load_if_dec, load_dec_ex, load_ex_wb,
                        squash_if_dec, squash_dec_ex}), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        resp_a = 1'b1; resp_b = 1'b1;
        dec_valid = 1'b0; dec_rs1_num = '0; dec_rs2_num = '0;
        ex_valid = 1'b0; ex_rd = '0; ex_load_regfile = 1'b0; ex_is_load = 1'b0;
        br_taken = 1'b0;
        mem_valid = 1'b0; mem_rd = '0; mem_load_regfile = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        ex_valid = 1'b1; ex_load_regfile = 1'b1; ex_rd = 5'd5; dec_rs1_num = 5'd5;
        #1;
        check("rst_fwd1", 32'(fwd_rs1_sel), 32'd0);
        check_ctl("rst_ctl", 6'b000000);
        tick();
        tick();
        check("rst_stall", stall_count, 32'd0);
        check("rst_flush", flush_count, 32'd0);
        check("rst_tmo", 32'(mem_timeout), 32'd0);
        reset = 1'b0;

        // 1: forwarding
        #1;
        check("fwd_ex", 32'(fwd_rs1_sel), 32'd2);
        check_ctl("run_ctl", 6'b111100);
        ex_valid = 1'b0; mem_valid = 1'b1; mem_load_regfile = 1'b1; mem_rd = 5'd5;
        #1;
        check("fwd_mem", 32'(fwd_rs1_sel), 32'd1);
        ex_valid = 1'b1;
        #1;
        check("fwd_ex_over_mem", 32'(fwd_rs1_sel), 32'd2);
        ex_is_load = 1'b1;
        #1;
        check("fwd_exload_skip", 32'(fwd_rs1_sel), 32'd1);
        ex_is_load = 1'b0; dec_rs1_num = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
        #1;
        check("fwd_x0", 32'(fwd_rs1_sel), 32'd0);
        tick();

        // 2: load-use bubble
        idle_inputs();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_load_regfile = 1'b1; ex_rd = 5'd7;
        dec_valid = 1'b1; dec_rs2_num = 5'd7;
        #1;
        check_ctl("lu_ctl", 6'b001101);
        check("lu_fwd2", 32'(fwd_rs2_sel), 32'd0);
        tick();
        check("lu_stall", stall_count, 32'd1);
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_load_regfile = 1'b0;
        mem_valid = 1'b1; mem_load_regfile = 1'b1; mem_rd = 5'd7;
        #1;
        check("lu_next_fwd2", 32'(fwd_rs2_sel), 32'd1);
        check_ctl("lu_next_ctl", 6'b111100);
        tick();

        // 3: branch flush overrides load-use
        idle_inputs();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_load_regfile = 1'b1; ex_rd = 5'd7;
        dec_valid = 1'b1; dec_rs2_num = 5'd7; br_taken = 1'b1;
        #1;
        check_ctl("br_lu_ctl", 6'b111111);
        tick();
        check("br_flush", flush_count, 32'd1);
        check("br_stall", stall_count, 32'd1);

        // 4: D-memory stall with branch held in EX
        idle_inputs();
        ex_valid = 1'b1; br_taken = 1'b1; resp_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_ctl("dstall_ctl", 6'b000000);
            tick();
        end
        check("dstall_stall", stall_count, 32'd4);
        check("dstall_flush", flush_count, 32'd1);
        resp_b = 1'b1;
        #1;
        check_ctl("dstall_br_ctl", 6'b111111);
        tick();
        check("dstall_flush2", flush_count, 32'd2);
        check("dstall_stall2", stall_count, 32'd4);

        // 5: I-memory timeout
        idle_inputs();
        resp_a = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("tmo_before", 32'(mem_timeout), 32'd0);
        tick();
        check("tmo_after", 32'(mem_timeout), 32'd1);
        check("tmo_stall", stall_count, 32'd12);
        resp_a = 1'b1;
        #1;
        check_ctl("tmo_run_ctl", 6'b111100);
        tick();
        check("tmo_sticky", 32'(mem_timeout), 32'd1);

        // 6: reset during MEM_WAIT discards wait count
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_tmo", 32'(mem_timeout), 32'd0);
        resp_a = 1'b0;
        tick();
        tick();
        check("mw_stall", stall_count, 32'd2);
        reset = 1'b1;
        #1;
        check_ctl("mw_rst_ctl", 6'b000000);
        tick();
        reset = 1'b0;
        check("mw_rst_stall", stall_count, 32'd0);
        check("mw_rst_flush", flush_count, 32'd0);
        check("mw_rst_tmo", 32'(mem_timeout), 32'd0);
        for (int i = 0; i < 7; i++) tick();
        check("mw_tmo_before", 32'(mem_timeout), 32'd0);
        tick();
        check("mw_tmo_after", 32'(mem_timeout), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
